// File: rtl/pipe_pkg.sv
// Shared types and default constants for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam int          DEF_EXC_W      = 5;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (head + skid) pipeline stage with bubble insertion, exception flush
// and a saturating stall counter; in_ready is registered to cut the ready path.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              PAYLOAD_W  = 64,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = DEF_EXC_W,
  parameter int              CNT_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(DEF_HANDLER_PC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 in_bd,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 bubble,
  input  logic                 req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic                 out_bd,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_is_bubble,
  output logic [1:0]           count,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic                 bd;
    logic [EXC_W-1:0]     exc;
    logic                 is_bubble;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  localparam int TAIL_W = 1 + EXC_W + 1 + PAYLOAD_W;
  localparam entry_t RESET_ENTRY   = {RESET_PC, {TAIL_W{1'b0}}};
  localparam entry_t HANDLER_ENTRY = {HANDLER_PC, {TAIL_W{1'b0}}};

  state_t state_reg, state_next;
  entry_t head_reg, head_next;
  entry_t skid_reg, skid_next;
  entry_t in_entry, idle_entry;
  logic   in_ready_reg;
  logic   push, pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = (state_reg != EMPTY) & out_ready;

  always_comb begin
    in_entry.pc        = in_pc;
    in_entry.bd        = in_bd;
    in_entry.exc       = in_exc;
    in_entry.is_bubble = bubble;
    in_entry.payload   = bubble ? '0 : in_payload;
  end

  // An empty stage keeps showing the last head PC with all other fields cleared.
  assign idle_entry = {head_reg.pc, {TAIL_W{1'b0}}};

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (req) begin
      state_next = EMPTY;
      head_next  = HANDLER_ENTRY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_next  = in_entry;
            state_next = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_next = in_entry;
          end else if (pop) begin
            head_next  = idle_entry;
            state_next = EMPTY;
          end else if (push) begin
            skid_next  = in_entry;
            state_next = TWO;
          end
        end
        TWO: begin
          if (pop) begin
            head_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          head_next  = RESET_ENTRY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= EMPTY;
      head_reg     <= RESET_ENTRY;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = (state_reg != EMPTY);
  assign out_pc        = head_reg.pc;
  assign out_bd        = head_reg.bd;
  assign out_exc       = head_reg.exc;
  assign out_payload   = head_reg.payload;
  assign out_is_bubble = head_reg.is_bubble;
  assign count         = state_reg;

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised scoreboard bench for pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;

  localparam int PW = 64;
  localparam int AW = 32;
  localparam int EW = 5;
  localparam int CW = 4;
  localparam logic [AW-1:0] RST_PC = 32'h3000;
  localparam logic [AW-1:0] HND_PC = 32'h4180;
  localparam int STALL_MAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_pc = '0;
  logic          in_bd = 1'b0;
  logic [EW-1:0] in_exc = '0;
  logic [PW-1:0] in_payload = '0;
  logic          bubble = 1'b0;
  logic          req = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic          out_bd;
  logic [EW-1:0] out_exc;
  logic [PW-1:0] out_payload;
  logic          out_is_bubble;
  logic [1:0]    count;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W(PW), .PC_W(AW), .EXC_W(EW), .CNT_W(CW),
    .RESET_PC(RST_PC), .HANDLER_PC(HND_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_payload(in_payload),
    .bubble(bubble), .req(req),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
    .out_payload(out_payload), .out_is_bubble(out_is_bubble),
    .count(count), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic          bd;
    logic [EW-1:0] exc;
    logic          bub;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t          exp_q[$];
  logic [AW-1:0] exp_last_pc = RST_PC;
  int            exp_stall = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            m_pop, m_push;
  ent_t          m_ent;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of at most two entries.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_last_pc = RST_PC;
      exp_stall   = 0;
    end else begin
      if (exp_q.size() > 0 && !out_ready && exp_stall < STALL_MAX) exp_stall++;
      if (req) begin
        exp_q.delete();
        exp_last_pc = HND_PC;
      end else begin
        m_pop  = (exp_q.size() > 0) && out_ready;
        m_push = in_valid && (exp_q.size() < 2);
        if (m_pop) begin
          exp_last_pc = exp_q[0].pc;
          void'(exp_q.pop_front());
        end
        if (m_push) begin
          m_ent.pc  = in_pc;
          m_ent.bd  = in_bd;
          m_ent.exc = in_exc;
          m_ent.bub = bubble;
          m_ent.pl  = bubble ? '0 : in_payload;
          exp_q.push_back(m_ent);
        end
      end
    end
  end

  // Monitor: compares the presented head and status against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (exp_q.size() > 0) begin
        chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        chk("out_bd", 64'(out_bd), 64'(exp_q[0].bd));
        chk("out_exc", 64'(out_exc), 64'(exp_q[0].exc));
        chk("out_is_bubble", 64'(out_is_bubble), 64'(exp_q[0].bub));
        chk("out_payload", out_payload, exp_q[0].pl);
        if (out_ready)
          $display("pop pc=%h bd=%0d exc=%0d bub=%0d payload=%h",
                   out_pc, out_bd, out_exc, out_is_bubble, out_payload);
      end else begin
        chk("idle_pc", 64'(out_pc), 64'(exp_last_pc));
        chk("idle_fields", {58'd0, out_bd, out_exc}, 64'd0);
        chk("idle_payload", out_payload, 64'd0);
        chk("idle_bubble", 64'(out_is_bubble), 64'd0);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [AW-1:0] pc, input logic bd,
                     input logic [EW-1:0] exc, input logic [PW-1:0] pl,
                     input logic bub, input logic rq, input logic ordy);
    @(negedge clk);
    #1;
    in_valid   = iv;
    in_pc      = pc;
    in_bd      = bd;
    in_exc     = exc;
    in_payload = pl;
    bubble     = bub;
    req        = rq;
    out_ready  = ordy;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_pc", 64'(out_pc), 64'(RST_PC));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b1;

    // Single push, 1-cycle latency
    cyc(1'b1, 32'h3004, 1'b0, 5'd0, 64'h1234, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill both entries under backpressure, then drain in order
    cyc(1'b1, 32'h3100, 1'b0, 5'd1, 64'hAAAA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3104, 1'b1, 5'd2, 64'hBBBB, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    repeat (3) idle(1'b1);

    // Bubble push keeps pc/bd/exc, clears payload
    cyc(1'b1, 32'h3010, 1'b1, 5'd4, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush from TWO with a simultaneous push, then from ONE with an accepted push
    cyc(1'b1, 32'h3200, 1'b0, 5'd0, 64'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3204, 1'b0, 5'd0, 64'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3208, 1'b0, 5'd0, 64'h33, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #1;
    chk("flush_pc", 64'(out_pc), 64'(HND_PC));
    chk("flush_count", 64'(count), 64'd0);
    cyc(1'b1, 32'h3300, 1'b0, 5'd0, 64'h44, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3304, 1'b0, 5'd0, 64'h55, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset while full
    cyc(1'b1, 32'h3400, 1'b0, 5'd0, 64'h66, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3404, 1'b0, 5'd0, 64'h77, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'(RST_PC));
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Stall counter saturation
    cyc(1'b1, 32'h3500, 1'b0, 5'd3, 64'h88, 1'b0, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    @(negedge clk);
    #1;
    chk("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), {$urandom, $urandom},
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3)));
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter PAYLOAD_W, default 64, width of the opaque stage payload (instruction, operands, immediates, register indices).
REQ-002 Parameter PC_W, default 32, width of the carried PC.
REQ-003 Parameter EXC_W, default 5, width of the carried exception code.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 Parameter RESET_PC, default 32'h3000, PC shown after reset.
REQ-006 Parameter HANDLER_PC, default 32'h4180, PC shown after an exception request.
REQ-007 Ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-008 in_valid  in  1  upstream entry offered; in_ready  out  1  stage can accept.
REQ-009 in_pc  in  PC_W; in_bd  in  1 (branch-delay flag); in_exc  in  EXC_W; in_payload  in  PAYLOAD_W.
REQ-010 bubble  in  1  convert the accepted entry into a nop; req  in  1  exception request, flush stage.
REQ-011 out_valid  out  1; out_ready  in  1  downstream accepts head.
REQ-012 out_pc  out  PC_W; out_bd  out  1; out_exc  out  EXC_W; out_payload  out  PAYLOAD_W; out_is_bubble  out  1.
REQ-013 count  out  2  occupancy 0..2; stall_cnt  out  CNT_W  cycles head was blocked.

Function
REQ-014 The block SHALL be a 2-entry in-order buffer (head plus skid) with state EMPTY, ONE, TWO; count SHALL equal the state.
REQ-015 Push = in_valid & in_ready; pop = out_valid & out_ready; in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and registered (no combinational path from out_ready).
REQ-016 Transitions: EMPTY+push->ONE; ONE+push+pop->ONE (new entry becomes head); ONE+pop->EMPTY; ONE+push->TWO; TWO+pop->ONE (skid moves to head); otherwise hold.
REQ-017 Latency SHALL be exactly 1 cycle from push in EMPTY to out_valid=1 with the pushed fields.
REQ-018 out_valid SHALL be 1 iff count>0; out_* SHALL show the head entry and SHALL hold stable while out_valid & !out_ready.
REQ-019 When EMPTY: out_payload=0, out_bd=0, out_exc=0, out_is_bubble=0, out_pc retains its last value.
REQ-020 bubble=1 on a push SHALL store payload=0 and is_bubble=1 while keeping in_pc, in_bd, in_exc; bubble without push SHALL be ignored.
REQ-021 req=1 SHALL take priority over push, pop and bubble: next cycle state EMPTY, out_pc=HANDLER_PC, other outputs zero, any same-cycle push discarded.
REQ-022 stall_cnt SHALL increment by 1 each cycle out_valid & !out_ready, saturate at all-ones, and be unaffected by req.
REQ-023 Entry ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by req.

Reset
REQ-024 On reset low, asynchronously: state EMPTY, in_ready=1, out_valid=0, out_pc=RESET_PC, out_bd=0, out_exc=0, out_payload=0, out_is_bubble=0, stall_cnt=0.
REQ-025 Reset asserted mid-operation SHALL discard both entries; the first push after release SHALL behave as REQ-017.

Structure
REQ-026 Package pipe_pkg SHALL hold the state enumeration and default RESET_PC, HANDLER_PC and EXC_W constants.
REQ-027 The stall counter SHALL be a sub-module pipe_sat_cnt (width-parametrised, saturating, async active-low reset).
REQ-028 Head and skid entries SHALL each be one packed record {pc, bd, exc, is_bubble, payload}.

Verification
REQ-029 Reset, push pc=0x3004 payload=0x1234 with out_ready=1 -> next cycle out_valid=1, out_pc=0x3004, out_payload=0x1234, count=1.
REQ-030 Push A, B with out_ready=0 -> count=2, in_ready=0, stall_cnt counts; raise out_ready -> A then B on consecutive cycles.
REQ-031 Push with bubble=1, in_pc=0x3010, in_bd=1, in_exc=4 -> out_payload=0, out_is_bubble=1, out_pc=0x3010, out_bd=1, out_exc=4.
REQ-032 State TWO, req=1 with simultaneous push -> next cycle count=0, out_valid=0, out_pc=0x4180, pushed entry absent.
REQ-033 CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
REQ-034 Reset low while count=2 -> immediately out_valid=0, out_pc=0x3000, stall_cnt=0.
